// File: rtl/template_matcher.sv
// Streaming nearest-template classifier: accumulates SAD (MODE=0) or SSD (MODE=1)
// of one ROWS x COLS frame against every stored template, then picks the minimum.
module template_matcher #(
    parameter int ROWS          = 11,
    parameter int COLS          = 11,
    parameter int PIX_W         = 8,
    parameter int NUM_TEMPLATES = 10,
    parameter int MODE          = 0,
    parameter int SCORE_W       = 24,
    localparam int NPIX   = ROWS * COLS,
    localparam int IDX_W  = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1,
    localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    input  logic [PIX_W-1:0]   pix_data_i,
    input  logic               tmpl_wr_en_i,
    input  logic [IDX_W-1:0]   tmpl_wr_idx_i,
    input  logic [ADDR_W-1:0]  tmpl_wr_addr_i,
    input  logic [PIX_W-1:0]   tmpl_wr_data_i,
    output logic               busy_o,
    output logic               result_valid_o,
    input  logic               result_ack_i,
    output logic [IDX_W-1:0]   match_idx_o,
    output logic [SCORE_W-1:0] match_score_o
);
    localparam int DIST_W = 2 * PIX_W;
    localparam int SUM_W  = ((SCORE_W > DIST_W) ? SCORE_W : DIST_W) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TEMPLATES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
    state_t state_q, state_d;

    logic [PIX_W-1:0]   tmem_q [NUM_TEMPLATES][NPIX];
    logic [SCORE_W-1:0] acc_q  [NUM_TEMPLATES];
    logic [ADDR_W-1:0]  cnt_q;
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W-1:0]   best_idx_q, match_idx_q;
    logic [SCORE_W-1:0] best_q, match_score_q;
    logic               pix_fire;
    logic               cmp_take;

    // Per-pixel distance; the signed difference is exact for any pair of samples.
    function automatic logic [DIST_W-1:0] dist_f(input logic [PIX_W-1:0] p,
                                                 input logic [PIX_W-1:0] q);
        logic signed [PIX_W:0]     diff;
        logic signed [PIX_W:0]     mag;
        logic signed [2*PIX_W+1:0] sq;
        diff = $signed({1'b0, p}) - $signed({1'b0, q});
        mag  = (diff < 0) ? -diff : diff;
        sq   = diff * diff;
        if (MODE == 1) return DIST_W'(sq);
        return DIST_W'(mag);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add_f(input logic [SCORE_W-1:0] a,
                                                     input logic [DIST_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({SCORE_W{1'b1}})) return '1;
        return SCORE_W'(s);
    endfunction

    assign pix_fire      = (state_q == ACCUM) && pix_valid_i;
    assign cmp_take      = (k_q == '0) || (acc_q[k_q] < best_q);
    assign match_idx_o   = match_idx_q;
    assign match_score_o = match_score_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        pix_ready_o    = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ACCUM;
            end
            ACCUM: begin
                pix_ready_o = 1'b1;
                if (pix_valid_i && (cnt_q == LAST_ADDR)) state_d = COMPARE;
            end
            COMPARE: begin
                if (k_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                result_valid_o = 1'b1;
                if (result_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Template store is deliberately outside reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if ((state_q == IDLE) && tmpl_wr_en_i &&
            (int'(tmpl_wr_idx_i) < NUM_TEMPLATES) && (int'(tmpl_wr_addr_i) < NPIX))
            tmem_q[tmpl_wr_idx_i][tmpl_wr_addr_i] <= tmpl_wr_data_i;
    end

    // Accumulate stage: all templates updated in parallel per accepted pixel.
    always_ff @(posedge clk_i) begin
        if (reset_i || ((state_q == IDLE) && start_i)) begin
            cnt_q <= '0;
            for (int t = 0; t < NUM_TEMPLATES; t++) acc_q[t] <= '0;
        end else if (pix_fire) begin
            cnt_q <= cnt_q + 1'b1;
            for (int t = 0; t < NUM_TEMPLATES; t++)
                acc_q[t] <= sat_add_f(acc_q[t], dist_f(pix_data_i, tmem_q[t][cnt_q]));
        end
    end

    // Compare stage: sequential minimum scan, strict less-than keeps the lower index on ties.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            k_q           <= '0;
            match_idx_q   <= '0;
            match_score_q <= '0;
        end else if (state_q == COMPARE) begin
            k_q <= k_q + 1'b1;
            if (k_q == LAST_IDX) begin
                match_idx_q   <= cmp_take ? k_q : best_idx_q;
                match_score_q <= cmp_take ? acc_q[k_q] : best_q;
            end
        end else begin
            k_q <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == COMPARE) && cmp_take) begin
            best_idx_q <= k_q;
            best_q     <= acc_q[k_q];
        end
    end
endmodule

// File: tb/tb_template_matcher.sv
// Scoreboard bench for template_matcher: dut0 runs SAD with 24-bit scores,
// dut1 runs SSD with 16-bit scores to exercise saturation.
`timescale 1ns/1ps
module tb_template_matcher;
    localparam int NT   = 10;
    localparam int NPIX = 121;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset   [2];
    logic        start   [2];
    logic        pv      [2];
    logic        pr      [2];
    logic [7:0]  pd      [2];
    logic        wr_en   [2];
    logic [3:0]  wr_idx  [2];
    logic [6:0]  wr_addr [2];
    logic [7:0]  wr_data [2];
    logic        busy    [2];
    logic        rv      [2];
    logic        ack     [2];
    logic [3:0]  mi      [2];
    logic [23:0] ms0;
    logic [15:0] ms1;

    template_matcher #(.MODE(0), .SCORE_W(24)) dut0 (
        .clk_i(clk), .reset_i(reset[0]), .start_i(start[0]),
        .pix_valid_i(pv[0]), .pix_ready_o(pr[0]), .pix_data_i(pd[0]),
        .tmpl_wr_en_i(wr_en[0]), .tmpl_wr_idx_i(wr_idx[0]),
        .tmpl_wr_addr_i(wr_addr[0]), .tmpl_wr_data_i(wr_data[0]),
        .busy_o(busy[0]), .result_valid_o(rv[0]), .result_ack_i(ack[0]),
        .match_idx_o(mi[0]), .match_score_o(ms0));

    template_matcher #(.MODE(1), .SCORE_W(16)) dut1 (
        .clk_i(clk), .reset_i(reset[1]), .start_i(start[1]),
        .pix_valid_i(pv[1]), .pix_ready_o(pr[1]), .pix_data_i(pd[1]),
        .tmpl_wr_en_i(wr_en[1]), .tmpl_wr_idx_i(wr_idx[1]),
        .tmpl_wr_addr_i(wr_addr[1]), .tmpl_wr_data_i(wr_data[1]),
        .busy_o(busy[1]), .result_valid_o(rv[1]), .result_ack_i(ack[1]),
        .match_idx_o(mi[1]), .match_score_o(ms1));

    typedef struct packed {
        int idx;
        int score;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    int   last_acc [2];
    logic rv_prev  [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] score_of(input int d);
        return (d == 0) ? 32'(ms0) : 32'(ms1);
    endfunction

    // Monitor: pops the scoreboard whenever a DUT raises result_valid.
    initial begin
        exp_t e;
        last_acc[0] = 0; last_acc[1] = 0;
        rv_prev[0]  = 1'b0; rv_prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            for (int d = 0; d < 2; d++) begin
                if (pv[d] === 1'b1 && pr[d] === 1'b1) last_acc[d] = ncyc + 1;
                if (rv[d] === 1'b1 && rv_prev[d] !== 1'b1) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result dut%0d idx=%0d score=%0d", d, mi[d], score_of(d));
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("dut%0d_match_idx", d), 32'(mi[d]), e.idx);
                        check($sformatf("dut%0d_match_score", d), score_of(d), e.score);
                        check($sformatf("dut%0d_latency", d), ncyc - last_acc[d], NT);
                        check($sformatf("dut%0d_pix_ready_in_done", d), 32'(pr[d]), 0);
                    end
                end
                rv_prev[d] = rv[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] tval(input int scen, input int t, input int a);
        case (scen)
            0: return (t == 7) ? 8'd5 : 8'd0;
            1: return (t == 2 || t == 4) ? 8'd10 : 8'd200;
            2: return (t == 3) ? 8'((a * 7) % 256) : ((t == 2 || t == 4) ? 8'd10 : 8'd200);
            4: return (t == 1) ? 8'd252 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] fpix(input int kind, input int c, input int a);
        return (kind == 1) ? 8'((a * 7) % 256) : 8'(c);
    endfunction

    task automatic load(input int d, input int scen);
        for (int t = 0; t < NT; t++) begin
            for (int a = 0; a < NPIX; a++) begin
                wr_en[d]   = 1'b1;
                wr_idx[d]  = 4'(t);
                wr_addr[d] = 7'(a);
                wr_data[d] = tval(scen, t, a);
                tick();
            end
        end
        wr_en[d] = 1'b0;
    endtask

    // gaps: random pix_valid holes with start/ack noise; noise: T[3] writes during ACCUM.
    task automatic run_frame(input int d, input int kind, input int c, input bit gaps,
                             input bit noise, input int abort_at, input int ei, input int es);
        exp_t e;
        int   a;
        if (abort_at < 0) begin
            e.idx   = ei;
            e.score = es;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        a = 0;
        while (a < NPIX && a != abort_at) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                pv[d]    = 1'b0;
                start[d] = 1'b1;
                ack[d]   = 1'b1;
            end else begin
                pv[d] = 1'b1;
                pd[d] = fpix(kind, c, a);
                if (noise) begin
                    wr_en[d]   = 1'b1;
                    wr_idx[d]  = 4'd3;
                    wr_addr[d] = 7'(a);
                    wr_data[d] = ~pd[d];
                end
            end
            tick();
            if (pv[d]) a++;
            pv[d] = 1'b0; start[d] = 1'b0; ack[d] = 1'b0; wr_en[d] = 1'b0;
        end
    endtask

    task automatic finish_frame(input int d, input int ei, input int es);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 4 * NT && !got; n++) begin
            @(negedge clk);
            if (rv[d] === 1'b1) got = 1'b1;
            else check($sformatf("dut%0d_pix_ready_in_compare", d), 32'(pr[d]), 0);
        end
        check($sformatf("dut%0d_result_seen", d), 32'(got), 1);
        if (got) begin
            repeat (2) begin
                @(negedge clk);
                check($sformatf("dut%0d_result_held", d), 32'(rv[d]), 1);
            end
            @(posedge clk);
            #1;
            ack[d] = 1'b1;
            tick();
            ack[d] = 1'b0;
            @(negedge clk);
            check($sformatf("dut%0d_valid_after_ack", d), 32'(rv[d]), 0);
            check($sformatf("dut%0d_busy_after_ack", d), 32'(busy[d]), 0);
            check($sformatf("dut%0d_idx_hold", d), 32'(mi[d]), ei);
            check($sformatf("dut%0d_score_hold", d), score_of(d), es);
        end
    endtask

    task automatic chk_idle(input int d);
        check($sformatf("dut%0d_rst_pix_ready", d), 32'(pr[d]), 0);
        check($sformatf("dut%0d_rst_busy", d), 32'(busy[d]), 0);
        check($sformatf("dut%0d_rst_valid", d), 32'(rv[d]), 0);
        check($sformatf("dut%0d_rst_idx", d), 32'(mi[d]), 0);
        check($sformatf("dut%0d_rst_score", d), score_of(d), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; start[d] = 1'b0; pv[d] = 1'b0; pd[d] = '0;
            wr_en[d] = 1'b0; wr_idx[d] = '0; wr_addr[d] = '0; wr_data[d] = '0;
            ack[d] = 1'b0;
        end
        tick();
        tick();
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        @(negedge clk);
        chk_idle(0);
        chk_idle(1);

        // Single exact match: T[7]=5 vs others 0 scores 605.
        load(0, 0);
        run_frame(0, 0, 5, 1'b0, 1'b0, -1, 7, 0);
        finish_frame(0, 7, 0);

        // Tie at 242 between T[2] and T[4]; lower index wins.
        load(0, 1);
        run_frame(0, 0, 12, 1'b0, 1'b0, -1, 2, 242);
        finish_frame(0, 2, 242);

        // Patterned T[3]: gapped stream, then back-to-back stream.
        load(0, 2);
        run_frame(0, 1, 0, 1'b1, 1'b0, -1, 3, 0);
        finish_frame(0, 3, 0);
        run_frame(0, 1, 0, 1'b0, 1'b0, -1, 3, 0);
        finish_frame(0, 3, 0);

        // Template writes during ACCUM must be ignored, now and for the next frame.
        run_frame(0, 1, 0, 1'b0, 1'b1, -1, 3, 0);
        finish_frame(0, 3, 0);
        run_frame(0, 1, 0, 1'b0, 1'b0, -1, 3, 0);
        finish_frame(0, 3, 0);

        // Reset after 60 accepted pixels, then a clean frame.
        run_frame(0, 1, 0, 1'b0, 1'b0, 60, 0, 0);
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        @(negedge clk);
        chk_idle(0);
        run_frame(0, 1, 0, 1'b0, 1'b0, -1, 3, 0);
        finish_frame(0, 3, 0);

        // SSD, 16-bit: all templates 0 vs 255 saturate; then T[1]=252 gives 121*9.
        load(1, 3);
        run_frame(1, 0, 255, 1'b0, 1'b0, -1, 0, 65535);
        finish_frame(1, 0, 65535);
        load(1, 4);
        run_frame(1, 0, 255, 1'b0, 1'b0, -1, 1, 1089);
        finish_frame(1, 1, 1089);

        repeat (3) tick();
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
